// File: rtl/clock_pkg.sv
// Shared widths, limits, FSM states and field-select encodings for the
// time-of-day counter and its set controller.
package clock_pkg;

    localparam int unsigned H_W    = 5;
    localparam int unsigned M_W    = 6;
    localparam int unsigned S_W    = 6;
    localparam int unsigned TIME_W = 17;

    localparam int unsigned HOUR_MAX   = 23;
    localparam int unsigned MINSEC_MAX = 59;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_H,
        ST_SET_M,
        ST_SET_S,
        ST_COMMIT
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HOUR = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_SEC  = 2'd3;

endpackage

// File: rtl/wrap_step.sv
// Combinational +1/-1 of a field with modular wrap over 0..MAX.
// Both or neither of inc/dec leaves the value unchanged.
module wrap_step #(
    parameter int unsigned W   = 6,
    parameter int unsigned MAX = 59
) (
    input  logic [W-1:0] val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] nxt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE   = W'(1);

    always_comb begin
        nxt = val;
        if (inc && !dec) begin
            nxt = (val == MAX_V) ? '0 : val + ONE;
        end else if (dec && !inc) begin
            nxt = (val == '0) ? MAX_V : val - ONE;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Operator time-set FSM: hour -> minute -> second edit with blink phase,
// idle timeout, and a single-cycle load strobe into the time counter.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TIME_1S    = 50_000_000,
    parameter int unsigned BLINK_HALF = TIME_1S / 4,
    parameter int unsigned TIMEOUT_S  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_mode,
    input  logic              key_inc,
    input  logic              key_dec,
    input  logic [TIME_W-1:0] time_cur,
    output logic              run_en,
    output logic              load,
    output logic [TIME_W-1:0] load_val,
    output logic [1:0]        edit_sel,
    output logic              blink
);

    localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF - 1);
    localparam logic [31:0] IDLE_LAST  = 32'(TIMEOUT_S * TIME_1S - 1);

    state_t         state;
    logic [H_W-1:0] edit_h, h_nxt;
    logic [M_W-1:0] edit_m, m_nxt;
    logic [S_W-1:0] edit_s, s_nxt;
    logic [31:0]    blink_cnt;
    logic [31:0]    idle_cnt;
    logic           any_step;
    logic           accepted_step;
    logic           blink_wrap;

    assign any_step      = key_inc | key_dec;
    assign accepted_step = key_inc ^ key_dec;
    assign blink_wrap    = (blink_cnt == BLINK_LAST);

    wrap_step #(.W(H_W), .MAX(HOUR_MAX))   u_step_h (.val(edit_h), .inc(key_inc), .dec(key_dec), .nxt(h_nxt));
    wrap_step #(.W(M_W), .MAX(MINSEC_MAX)) u_step_m (.val(edit_m), .inc(key_inc), .dec(key_dec), .nxt(m_nxt));
    wrap_step #(.W(S_W), .MAX(MINSEC_MAX)) u_step_s (.val(edit_s), .inc(key_inc), .dec(key_dec), .nxt(s_nxt));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            run_en    <= 1'b1;
            load      <= 1'b0;
            load_val  <= '0;
            edit_sel  <= SEL_NONE;
            blink     <= 1'b0;
            edit_h    <= '0;
            edit_m    <= '0;
            edit_s    <= '0;
            blink_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            load <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (key_mode) begin
                        edit_h    <= time_cur[16:12];
                        edit_m    <= time_cur[11:6];
                        edit_s    <= time_cur[5:0];
                        state     <= ST_SET_H;
                        run_en    <= 1'b0;
                        edit_sel  <= SEL_HOUR;
                        blink     <= 1'b1;
                        blink_cnt <= '0;
                        idle_cnt  <= '0;
                    end
                end
                ST_SET_H, ST_SET_M, ST_SET_S: begin
                    if (key_mode) begin
                        blink_cnt <= '0;
                        idle_cnt  <= '0;
                        if (state == ST_SET_H) begin
                            state    <= ST_SET_M;
                            edit_sel <= SEL_MIN;
                            blink    <= 1'b1;
                        end else if (state == ST_SET_M) begin
                            state    <= ST_SET_S;
                            edit_sel <= SEL_SEC;
                            blink    <= 1'b1;
                        end else begin
                            state    <= ST_COMMIT;
                            load     <= 1'b1;
                            load_val <= {edit_h, edit_m, edit_s};
                            run_en   <= 1'b1;
                            edit_sel <= SEL_NONE;
                            blink    <= 1'b0;
                        end
                    end else if (any_step) begin
                        // inc+dec together still counts as activity but leaves blink running
                        idle_cnt <= '0;
                        if (accepted_step) begin
                            blink     <= 1'b1;
                            blink_cnt <= '0;
                            case (state)
                                ST_SET_H: edit_h <= h_nxt;
                                ST_SET_M: edit_m <= m_nxt;
                                ST_SET_S: edit_s <= s_nxt;
                                default:  ;
                            endcase
                        end else if (blink_wrap) begin
                            blink     <= ~blink;
                            blink_cnt <= '0;
                        end else begin
                            blink_cnt <= blink_cnt + 32'd1;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        state     <= ST_RUN;
                        run_en    <= 1'b1;
                        edit_sel  <= SEL_NONE;
                        blink     <= 1'b0;
                        blink_cnt <= '0;
                        idle_cnt  <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                        if (blink_wrap) begin
                            blink     <= ~blink;
                            blink_cnt <= '0;
                        end else begin
                            blink_cnt <= blink_cnt + 32'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
